// File: rtl/redirect_ctrl_if.sv
// Redirect controller bus: event inputs from stage 2 / CSR unit and the
// redirect handshake toward fetch.
interface redirect_ctrl_if;
  logic        br_taken_c;
  logic [31:0] br_target_i;
  logic        stall_i;
  logic        mret_i;
  logic [31:0] epc_i;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic        fetch_ready_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [1:0]  redirect_src_o;
  logic        flush_fd_o;
  logic        trap_ack_o;
  logic        busy_o;

  modport slave (
    input  br_taken_c, br_target_i, stall_i, mret_i, epc_i,
    input  trap_req_i, trap_vec_i, fetch_ready_i,
    output redirect_valid_o, redirect_pc_o, redirect_src_o,
    output flush_fd_o, trap_ack_o, busy_o
  );

  modport master (
    output br_taken_c, br_target_i, stall_i, mret_i, epc_i,
    output trap_req_i, trap_vec_i, fetch_ready_i,
    input  redirect_valid_o, redirect_pc_o, redirect_src_o,
    input  flush_fd_o, trap_ack_o, busy_o
  );
endinterface

// File: rtl/redirect_ctrl.sv
// PC redirect sequencer: arbitrates trap/mret/branch redirects, holds one
// registered redirect until fetch accepts it, then flushes fetch/decode.
module redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_MRET = 2'b10;
  localparam logic [1:0] SRC_TRAP = 2'b11;
  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 32'd1);

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:1], 1'b0};
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [1:0]  src_r, src_s;
  logic [1:0]  cnt_r, cnt_s;
  logic        ack_s;

  logic        trap_ev_s, mret_ev_s, br_ev_s;
  logic        win_valid_s;
  logic [31:0] win_pc_s;
  logic [1:0]  win_src_s;

  assign trap_ev_s = bus.trap_req_i;
  assign mret_ev_s = bus.mret_i & ~bus.stall_i;
  assign br_ev_s   = bus.br_taken_c & ~bus.stall_i;

  // Fixed-priority pick among simultaneous events; losers are dropped.
  always_comb begin
    win_valid_s = 1'b0;
    win_pc_s    = 32'd0;
    win_src_s   = SRC_NONE;
    if (trap_ev_s) begin
      win_valid_s = 1'b1;
      win_pc_s    = align_pc(bus.trap_vec_i);
      win_src_s   = SRC_TRAP;
    end else if (mret_ev_s) begin
      win_valid_s = 1'b1;
      win_pc_s    = align_pc(bus.epc_i);
      win_src_s   = SRC_MRET;
    end else if (br_ev_s) begin
      win_valid_s = 1'b1;
      win_pc_s    = align_pc(bus.br_target_i);
      win_src_s   = SRC_BR;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Next-state logic for the redirect FSM.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    src_s   = src_r;
    cnt_s   = cnt_r;
    ack_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) begin
          pc_s    = win_pc_s;
          src_s   = win_src_s;
          ack_s   = trap_ev_s;
          state_s = ST_REDIR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REDIR: begin
        // A trap replacing a non-trap redirect voids any same-cycle handshake.
        if (trap_ev_s && (src_r != SRC_TRAP)) begin
          pc_s    = align_pc(bus.trap_vec_i);
          src_s   = SRC_TRAP;
          ack_s   = 1'b1;
          state_s = ST_REDIR;
        end else if (bus.fetch_ready_i) begin
          if (FLUSH_CYCLES == 32'd1) begin
            state_s = ST_IDLE;
          end else begin
            cnt_s   = CNT_INIT;
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_REDIR;
        end
      end
      ST_FLUSH: begin
        // cnt_r holds the number of FLUSH cycles still to be spent, this one included.
        if (trap_ev_s) begin
          pc_s    = align_pc(bus.trap_vec_i);
          src_s   = SRC_TRAP;
          ack_s   = 1'b1;
          state_s = ST_REDIR;
        end else if (cnt_r <= 2'd1) begin
          cnt_s   = 2'd0;
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r - 2'd1;
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pc_r    <= 32'd0;
      src_r   <= SRC_NONE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      src_r   <= src_s;
      cnt_r   <= cnt_s;
    end
  end

  assign bus.redirect_valid_o = (state_r == ST_REDIR);
  assign bus.redirect_pc_o    = (state_r == ST_REDIR) ? pc_r : 32'd0;
  assign bus.redirect_src_o   = (state_r == ST_REDIR) ? src_r : SRC_NONE;
  assign bus.flush_fd_o       = (state_r == ST_REDIR) || (state_r == ST_FLUSH);
  assign bus.busy_o           = (state_r != ST_IDLE);
  assign bus.trap_ack_o       = ack_s & ~rst;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed, table-driven bench for redirect_ctrl with FLUSH_CYCLES = 2.
module tb_redirect_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  redirect_ctrl_if bus ();

  redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        mret;
    logic [31:0] epc;
    logic        trap;
    logic [31:0] vec;
    logic        stall;
    logic        rdy;
    logic [37:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected output packing: {valid, pc, src, flush, ack, busy}
  function automatic logic [37:0] ez(input logic ack);
    return {1'b0, 32'd0, 2'b00, 1'b0, ack, 1'b0};
  endfunction
  function automatic logic [37:0] er(input logic [31:0] pc, input logic [1:0] src, input logic ack);
    return {1'b1, pc, src, 1'b1, ack, 1'b1};
  endfunction
  function automatic logic [37:0] ef(input logic ack);
    return {1'b0, 32'd0, 2'b00, 1'b1, ack, 1'b1};
  endfunction

  function automatic void add(input logic br, input logic [31:0] tgt, input logic mret,
                              input logic [31:0] epc, input logic trap, input logic [31:0] vec,
                              input logic stall, input logic rdy, input logic [37:0] exp);
    vec_t v;
    v.br = br; v.tgt = tgt; v.mret = mret; v.epc = epc; v.trap = trap;
    v.vec = vec; v.stall = stall; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic br, input logic [31:0] tgt, input logic mret,
                       input logic [31:0] epc, input logic trap, input logic [31:0] vec,
                       input logic stall, input logic rdy);
    @(negedge clk);
    rst               = r;
    bus.br_taken_c    = br;
    bus.br_target_i   = tgt;
    bus.mret_i        = mret;
    bus.epc_i         = epc;
    bus.trap_req_i    = trap;
    bus.trap_vec_i    = vec;
    bus.stall_i       = stall;
    bus.fetch_ready_i = rdy;
    #1;
  endtask

  task automatic chk(input string name, input logic [37:0] exp);
    logic [37:0] act;
    act = {bus.redirect_valid_o, bus.redirect_pc_o, bus.redirect_src_o,
           bus.flush_fd_o, bus.trap_ack_o, bus.busy_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {v,pc,src,fl,ack,busy}=%h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, rdy);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.br_taken_c = 1'b0; bus.br_target_i = 32'd0; bus.mret_i = 1'b0;
    bus.epc_i = 32'd0; bus.trap_req_i = 1'b0; bus.trap_vec_i = 32'd0;
    bus.stall_i = 1'b0; bus.fetch_ready_i = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, then branch with fetch always ready
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, ez(1'b0));
    add(1'b1, 32'h1005, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, ez(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, er(32'h1004, 2'b01, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, ez(1'b0));
    // Simultaneous trap, mret, branch
    add(1'b1, 32'h3000, 1'b1, 32'h2000, 1'b1, 32'h100, 1'b0, 1'b1, ez(1'b1));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, er(32'h100, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, ez(1'b0));
    // Trap overrides pending branch; second trap ignored
    add(1'b1, 32'h80,   1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, ez(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, er(32'h80, 2'b01, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, er(32'h80, 2'b01, 1'b1));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, er(32'h200, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, er(32'h200, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, er(32'h200, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    // Stall gating of branch/mret, trap still sampled
    add(1'b1, 32'h900,  1'b1, 32'hA00, 1'b0, 32'h0,   1'b1, 1'b1, ez(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    add(1'b1, 32'h900,  1'b1, 32'hA00, 1'b1, 32'h404, 1'b1, 1'b1, ez(1'b1));
    add(1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, er(32'h404, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    // mret with odd epc, trap during FLUSH
    add(1'b0, 32'h0,    1'b1, 32'h2001, 1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, er(32'h2000, 2'b10, 1'b0));
    add(1'b1, 32'h777,  1'b0, 32'h0,    1'b1, 32'h500, 1'b0, 1'b1, ef(1'b1));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, er(32'h500, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    // Trap replaces branch in the handshake cycle: handshake void
    add(1'b1, 32'h600,  1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 1'b1, er(32'h600, 2'b01, 1'b1));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, er(32'h700, 2'b11, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, ez(1'b0));
    // mret beats branch
    add(1'b1, 32'h3400, 1'b1, 32'h2400, 1'b0, 32'h0, 1'b0, 1'b1, ez(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b1, er(32'h2400, 2'b10, 1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b1, ef(1'b0));
    add(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0, 1'b0, 1'b1, ez(1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b0, tbl[i].br, tbl[i].tgt, tbl[i].mret, tbl[i].epc,
            tbl[i].trap, tbl[i].vec, tbl[i].stall, tbl[i].rdy);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Fetch stall: redirect held stable for 4 not-ready cycles
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("stall_ev", ez(1'b0));
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk($sformatf("stall_hold%0d", i), er(32'h40, 2'b01, 1'b0));
    end
    idle(1'b1);
    chk("stall_hs", er(32'h40, 2'b01, 1'b0));
    idle(1'b1);
    chk("stall_flush", ef(1'b0));
    idle(1'b1);
    chk("stall_idle", ez(1'b0));

    // Reset mid-REDIR discards the redirect; trap during rst gets no ack
    drive(1'b0, 1'b1, 32'h44, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_ev", ez(1'b0));
    idle(1'b0);
    chk("rst_redir", er(32'h44, 2'b01, 1'b0));
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h900, 1'b0, 1'b0);
    chk("rst_noack", er(32'h44, 2'b01, 1'b0));
    idle(1'b0);
    chk("rst_after", ez(1'b0));
    drive(1'b0, 1'b1, 32'h48, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("rst_br_ev", ez(1'b0));
    idle(1'b1);
    chk("rst_br_redir", er(32'h48, 2'b01, 1'b0));
    idle(1'b1);
    chk("rst_br_flush", ef(1'b0));
    idle(1'b1);
    chk("rst_br_idle", ez(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
